// File: rtl/axis_block_exerciser.sv
// AXI-Stream block generator/checker: sends BLOCK_LEN incrementing words, then receives and checks the processed block.
// Start to first word is one cycle; one word per cycle at full throughput; both ports follow valid/ready, so nothing is dropped.
module axis_block_exerciser #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    BLOCK_LEN    = 8,
  parameter logic [DATA_WIDTH-1:0] SEED         = DATA_WIDTH'(32'h0000_0010),
  parameter int                    EXPECT_DELTA = -1
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic                  start,
  input  logic [15:0]           num_blocks,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  input  logic                  m_axis_ready,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  s_axis_ready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic [15:0]           blocks_done
);

  localparam int                    IDX_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BLOCK_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] DELTA    = DATA_WIDTH'(EXPECT_DELTA);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t                state, state_d;
  logic [15:0]           nb_q;
  logic [DATA_WIDTH-1:0] tx_dat_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [IDX_W-1:0]      idx_q;
  logic [15:0]           err_q;
  logic [15:0]           blk_q;

  logic accept;
  logic tx_hs;
  logic rx_hs;
  logic blk_last;
  logic more_blocks;

  assign accept      = (state == IDLE) && start;
  assign tx_hs       = (state == SEND) && m_axis_ready;
  assign rx_hs       = (state == RECV) && s_axis_valid;
  assign blk_last    = (idx_q == LAST_IDX);
  assign more_blocks = ({1'b0, blk_q} + 17'd1) < {1'b0, nb_q};

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d      = state;
    m_axis_valid = 1'b0;
    s_axis_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = (num_blocks == 16'd0) ? DONE : SEND;
        end
      end
      SEND: begin
        m_axis_valid = 1'b1;
        busy         = 1'b1;
        if (tx_hs && blk_last) begin
          state_d = RECV;
        end
      end
      RECV: begin
        s_axis_ready = 1'b1;
        busy         = 1'b1;
        if (rx_hs && blk_last) begin
          state_d = more_blocks ? SEND : DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx_dat_q is SEED+k; exp_q tracks the next expected returned word, which
  // is the same global word index offset by DELTA.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      nb_q     <= '0;
      tx_dat_q <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      err_q    <= '0;
      blk_q    <= '0;
    end else if (accept) begin
      nb_q     <= num_blocks;
      tx_dat_q <= SEED;
      exp_q    <= SEED + DELTA;
      idx_q    <= '0;
      err_q    <= '0;
      blk_q    <= '0;
    end else if (tx_hs) begin
      tx_dat_q <= tx_dat_q + 1'b1;
      idx_q    <= blk_last ? '0 : idx_q + 1'b1;
    end else if (rx_hs) begin
      exp_q <= exp_q + 1'b1;
      idx_q <= blk_last ? '0 : idx_q + 1'b1;
      if ((s_axis_data != exp_q) && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
      if (blk_last) begin
        blk_q <= blk_q + 16'd1;
      end
    end
  end

  assign m_axis_data = tx_dat_q;
  assign err_count   = err_q;
  assign blocks_done = blk_q;

endmodule

// File: tb/tb_axis_block_exerciser.sv
// Directed bench: a buffering loopback stub returns sent-1 to the main instance; a second
// instance with a wrapping seed and 4-word blocks is driven from hand-computed tables.
module tb_axis_block_exerciser;

  logic        axi_clk;
  logic        axi_reset_n;
  logic        start;
  logic [15:0] num_blocks;
  logic        m_axis_valid;
  logic [31:0] m_axis_data;
  logic        m_axis_ready;
  logic        s_axis_valid;
  logic [31:0] s_axis_data;
  logic        s_axis_ready;
  logic        busy;
  logic        done;
  logic [15:0] err_count;
  logic [15:0] blocks_done;

  logic        w_start;
  logic [15:0] w_nb;
  logic        w_m_valid;
  logic [31:0] w_m_data;
  logic        w_m_ready;
  logic        w_s_valid;
  logic [31:0] w_s_data;
  logic        w_s_ready;
  logic        w_busy;
  logic        w_done;
  logic [15:0] w_err;
  logic [15:0] w_blk;

  int tests = 0;
  int fails = 0;

  // stub state
  logic [31:0] rx_q[$];
  logic [31:0] sent_q[$];
  int          tx_cnt, rx_cnt, done_cnt;
  int          corrupt_a, corrupt_b;
  logic        rnd_en;
  logic        prev_vld, prev_hs;
  logic [31:0] prev_dat;

  axis_block_exerciser dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .start(start), .num_blocks(num_blocks),
    .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_ready(m_axis_ready),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_ready(s_axis_ready),
    .busy(busy), .done(done), .err_count(err_count), .blocks_done(blocks_done)
  );

  axis_block_exerciser #(.DATA_WIDTH(32), .BLOCK_LEN(4), .SEED(32'hFFFF_FFFE), .EXPECT_DELTA(-1)) dut_wrap (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .start(w_start), .num_blocks(w_nb),
    .m_axis_valid(w_m_valid), .m_axis_data(w_m_data), .m_axis_ready(w_m_ready),
    .s_axis_valid(w_s_valid), .s_axis_data(w_s_data), .s_axis_ready(w_s_ready),
    .busy(w_busy), .done(w_done), .err_count(w_err), .blocks_done(w_blk)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_stub();
    rx_q.delete();
    sent_q.delete();
    tx_cnt   = 0;
    rx_cnt   = 0;
    done_cnt = 0;
    prev_vld = 1'b0;
    prev_hs  = 1'b0;
  endtask

  task automatic kick(input logic [15:0] nb);
    @(negedge axi_clk);
    start      = 1'b1;
    num_blocks = nb;
    @(negedge axi_clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge axi_clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  // Loopback stub and AXIS hold monitor; everything is decided at the falling edge
  // for the handshake that happens on the next rising edge.
  initial begin
    logic [31:0] w;
    m_axis_ready = 1'b0;
    s_axis_valid = 1'b0;
    s_axis_data  = 32'hDEAD_BEEF;
    forever begin
      @(negedge axi_clk);
      if (!axi_reset_n) begin
        prev_vld     = 1'b0;
        prev_hs      = 1'b0;
        m_axis_ready = 1'b0;
        s_axis_valid = 1'b0;
      end else begin
        if (prev_vld && !prev_hs) begin
          check("hold_valid", 32'(m_axis_valid), 32'd1);
          check("hold_data", m_axis_data, prev_dat);
        end
        if (done) done_cnt++;
        m_axis_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_vld = m_axis_valid;
        prev_dat = m_axis_data;
        prev_hs  = m_axis_valid && m_axis_ready;
        if (prev_hs) begin
          w = m_axis_data - 32'd1;
          if (tx_cnt == corrupt_a || tx_cnt == corrupt_b) w = w ^ 32'h0000_0100;
          rx_q.push_back(w);
          sent_q.push_back(m_axis_data);
          tx_cnt++;
        end
        s_axis_valid = (rx_q.size() > 0) && (rnd_en ? 1'($urandom_range(0, 1)) : 1'b1);
        s_axis_data  = s_axis_valid ? rx_q[0] : 32'hDEAD_BEEF;
        if (s_axis_valid && s_axis_ready) begin
          void'(rx_q.pop_front());
          rx_cnt++;
        end
      end
    end
  end

  initial begin
    logic [31:0] wsent[4];
    logic [31:0] wret[4];
    int          ti, ri, n;

    wsent = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    wret  = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};

    axi_reset_n = 1'b0;
    start       = 1'b0;
    num_blocks  = 16'd0;
    w_start     = 1'b0;
    w_nb        = 16'd0;
    w_m_ready   = 1'b0;
    w_s_valid   = 1'b0;
    w_s_data    = 32'd0;
    rnd_en      = 1'b0;
    corrupt_a   = -1;
    corrupt_b   = -1;
    clear_stub();

    // reset state
    repeat (3) @(negedge axi_clk);
    check("rst_m_valid", 32'(m_axis_valid), 32'd0);
    check("rst_m_data", m_axis_data, 32'd0);
    check("rst_s_ready", 32'(s_axis_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_blk", 32'(blocks_done), 32'd0);
    axi_reset_n = 1'b1;

    // full-rate loopback, 3 blocks
    clear_stub();
    kick(16'd3);
    check("t1_first_busy", 32'(busy), 32'd1);
    check("t1_first_valid", 32'(m_axis_valid), 32'd1);
    check("t1_first_data", m_axis_data, 32'h0000_0010);
    wait_done(200);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    check("t1_blk", 32'(blocks_done), 32'd3);
    check("t1_err", 32'(err_count), 32'd0);
    @(negedge axi_clk);
    check("t1_done_drop", 32'(done), 32'd0);
    check("t1_done_pulses", 32'(done_cnt), 32'd1);
    check("t1_handshakes", 32'(tx_cnt + rx_cnt), 32'd48);
    check("t1_sent_count", 32'(sent_q.size()), 32'd24);
    for (int j = 0; j < 24 && j < sent_q.size(); j++)
      check($sformatf("t1_sent_%0d", j), sent_q[j], 32'h10 + 32'(j));

    // random stalls on both ports, 2 blocks
    clear_stub();
    rnd_en = 1'b1;
    kick(16'd2);
    wait_done(1000);
    check("t2_err", 32'(err_count), 32'd0);
    check("t2_blk", 32'(blocks_done), 32'd2);
    check("t2_handshakes", 32'(tx_cnt + rx_cnt), 32'd32);
    rnd_en = 1'b0;
    @(negedge axi_clk);

    // corrupted words 2 and 13
    clear_stub();
    corrupt_a = 2;
    corrupt_b = 13;
    kick(16'd2);
    wait_done(200);
    check("t3_err", 32'(err_count), 32'd2);
    check("t3_blk", 32'(blocks_done), 32'd2);
    corrupt_a = -1;
    corrupt_b = -1;
    @(negedge axi_clk);

    // zero-block run clears counters and finishes at once
    clear_stub();
    kick(16'd0);
    check("t4_done_n1", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_err_cleared", 32'(err_count), 32'd0);
    check("t4_blk", 32'(blocks_done), 32'd0);
    @(negedge axi_clk);
    check("t4_done_n2", 32'(done), 32'd0);
    repeat (2) @(negedge axi_clk);
    check("t4_no_valid", 32'(tx_cnt), 32'd0);

    // start held high and num_blocks changed during the run
    clear_stub();
    @(negedge axi_clk);
    start      = 1'b1;
    num_blocks = 16'd1;
    @(negedge axi_clk);
    num_blocks = 16'd5;
    wait_done(200);
    start = 1'b0;
    repeat (4) @(negedge axi_clk);
    check("t4_hold_busy", 32'(busy), 32'd0);
    check("t4_hold_done_pulses", 32'(done_cnt), 32'd1);
    check("t4_hold_tx", 32'(tx_cnt), 32'd8);
    check("t4_hold_blk", 32'(blocks_done), 32'd1);

    // reset in the middle of receiving block 1
    clear_stub();
    corrupt_a = 3;
    kick(16'd3);
    n = 0;
    while (rx_cnt < 11 && n < 200) begin
      @(negedge axi_clk);
      n++;
    end
    check("t5_pre_s_ready", 32'(s_axis_ready), 32'd1);
    check("t5_pre_err", 32'(err_count), 32'd1);
    check("t5_pre_blk", 32'(blocks_done), 32'd1);
    axi_reset_n = 1'b0;
    clear_stub();
    corrupt_a = -1;
    #1;
    check("t5_rst_s_ready", 32'(s_axis_ready), 32'd0);
    check("t5_rst_m_valid", 32'(m_axis_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_err", 32'(err_count), 32'd0);
    check("t5_rst_blk", 32'(blocks_done), 32'd0);
    check("t5_rst_data", m_axis_data, 32'd0);
    repeat (2) @(negedge axi_clk);
    axi_reset_n = 1'b1;
    clear_stub();
    kick(16'd1);
    check("t5_restart_data", m_axis_data, 32'h0000_0010);
    wait_done(200);
    check("t5_restart_err", 32'(err_count), 32'd0);
    check("t5_restart_blk", 32'(blocks_done), 32'd1);
    check("t5_done_pulses", 32'(done_cnt), 32'd1);

    // wrapping seed on the 4-word instance
    w_m_ready = 1'b1;
    @(negedge axi_clk);
    w_start = 1'b1;
    w_nb    = 16'd1;
    @(negedge axi_clk);
    w_start = 1'b0;
    ti = 0;
    ri = 0;
    n  = 0;
    while (w_done !== 1'b1 && n < 40) begin
      if (w_m_valid && ti < 4) begin
        check($sformatf("wrap_sent_%0d", ti), w_m_data, wsent[ti]);
        ti++;
      end
      if (w_s_ready && ri < 4) begin
        w_s_valid = 1'b1;
        w_s_data  = wret[ri];
        ri++;
      end else begin
        w_s_valid = 1'b0;
      end
      @(negedge axi_clk);
      n++;
    end
    w_s_valid = 1'b0;
    check("wrap_done", 32'(w_done), 32'd1);
    check("wrap_sent_cnt", 32'(ti), 32'd4);
    check("wrap_ret_cnt", 32'(ri), 32'd4);
    check("wrap_err", 32'(w_err), 32'd0);
    check("wrap_blk", 32'(w_blk), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
